hconv_mc: RTL

HCONV_MC -- requirements
Module: hconv_mc

---
 rtl/hconv_mc.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/hconv_mc.sv
// -----------------------------------------------------------------------------
// hconv_mc -- multi-channel horizontal 1-D convolution with programmable
// signed taps, VALID (crop) or REPLICATE (edge-extend, same size) row modes.
//
// Ports
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_cfg_we/addr/wdata: coefficient write port (tap index, signed value)
//   i_mode             : 0 = VALID, 1 = REPLICATE (sampled at frame start)
//   i_vld/o_rdy        : input handshake, with i_eor/i_eof tags and i_data
//   o_vld/i_rdy        : output handshake, with o_eor/o_eof tags and o_data
//
// Pixels carry CH channels of DATA_W bits; channel k at [k*DATA_W +: DATA_W].
// A single output register gives one cycle of latency from the accept (or
// flush step) that completes a window to the registered result.
// -----------------------------------------------------------------------------
module hconv_mc #(
  parameter int DATA_W   = 8,
  parameter int CH       = 1,
  parameter int KERNEL_W = 7,
  parameter int COEF_W   = 6,
  parameter int SHIFT    = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cfg_we,
  input  logic [3:0]               i_cfg_addr,
  input  logic signed [COEF_W-1:0] i_cfg_wdata,
  input  logic                     i_mode,
  input  logic                     i_vld,
  input  logic                     i_eor,
  input  logic                     i_eof,
  input  logic [CH*DATA_W-1:0]     i_data,
  output logic                     o_rdy,
  input  logic                     i_rdy,
  output logic                     o_vld,
  output logic                     o_eor,
  output logic                     o_eof,
  output logic [CH*DATA_W-1:0]     o_data
);

  localparam int R     = (KERNEL_W - 1) / 2;
  localparam int COL_W = 16;
  // Product of a zero-extended sample and a signed coefficient, plus growth
  // for summing KERNEL_W terms and the rounding constant.
  localparam int ACC_W = DATA_W + COEF_W + 2 + $clog2(KERNEL_W);
  localparam logic signed [ACC_W-1:0] RND     = ACC_W'((SHIFT > 0) ? (1 << (SHIFT - 1)) : 0);
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((1 << DATA_W) - 1);

  typedef enum logic {S_RUN, S_FLUSH} state_t;

  state_t                     r_state, w_state_nxt;
  logic signed [COEF_W-1:0]   r_coef   [KERNEL_W];
  logic signed [COEF_W-1:0]   r_shadow [KERNEL_W];
  logic [DATA_W-1:0]          r_win     [CH][KERNEL_W];
  logic [DATA_W-1:0]          w_win_nxt [CH][KERNEL_W];
  logic [COL_W-1:0]           r_col;
  logic [3:0]                 r_flush_cnt;
  logic                       r_sof;
  logic                       r_mode;
  logic                       r_eof_pend;
  logic                       r_vld, r_eor, r_eof;
  logic [CH*DATA_W-1:0]       r_data;

  logic                       w_free, w_accept, w_step, w_mode, w_row_end;
  logic                       w_emit, w_tag_eor, w_tag_eof;
  logic signed [ACC_W-1:0]    w_acc, w_shf;
  logic [CH*DATA_W-1:0]       w_result;

  // Output register is free when empty or being drained this cycle.
  assign w_free    = !r_vld || i_rdy;
  assign o_rdy     = !i_rst && (r_state == S_RUN) && w_free;
  assign w_accept  = i_vld && o_rdy;
  assign w_step    = (r_state == S_FLUSH) && w_free;
  assign w_row_end = i_eor || i_eof;
  // The first accept of a frame already needs the new mode (column-0 load).
  assign w_mode    = r_sof ? i_mode : r_mode;

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= S_RUN;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every signal written here gets a default first so no path leaves it
  // unassigned; otherwise synthesis would infer a latch to hold the old value.
  always_comb begin
    w_state_nxt = r_state;
    w_emit      = 1'b0;
    w_tag_eor   = 1'b0;
    w_tag_eof   = 1'b0;
    if (r_state == S_RUN) begin
      if (w_accept) begin
        if (w_mode) begin
          w_emit = (r_col >= COL_W'(R));
          if (w_row_end) w_state_nxt = S_FLUSH;
        end else begin
          w_emit    = (r_col >= COL_W'(KERNEL_W - 1));
          w_tag_eor = w_row_end;
          w_tag_eof = i_eof;
        end
      end
    end else if (w_step) begin
      w_emit = 1'b1;
      if (r_flush_cnt == 4'(R - 1)) begin
        w_tag_eor   = 1'b1;
        w_tag_eof   = r_eof_pend;
        w_state_nxt = S_RUN;
      end
    end
  end

  // Window update: REPLICATE fills the whole window with column 0; a flush
  // step re-inserts the row's last pixel (the newest window entry).
  always_comb begin
    w_win_nxt = r_win;
    for (int c = 0; c < CH; c++) begin
      if (w_accept) begin
        for (int k = 0; k < KERNEL_W - 1; k++) begin
          w_win_nxt[c][k] = (w_mode && r_col == '0) ? i_data[c*DATA_W +: DATA_W] : r_win[c][k+1];
        end
        w_win_nxt[c][KERNEL_W-1] = i_data[c*DATA_W +: DATA_W];
      end else if (w_step) begin
        for (int k = 0; k < KERNEL_W - 1; k++) w_win_nxt[c][k] = r_win[c][k+1];
        w_win_nxt[c][KERNEL_W-1] = r_win[c][KERNEL_W-1];
      end
    end
  end

  // Filter arithmetic on the window as it will be after this cycle's update.
  always_comb begin
    w_result = '0;
    w_acc    = '0;
    w_shf    = '0;
    for (int c = 0; c < CH; c++) begin
      w_acc = RND;
      for (int k = 0; k < KERNEL_W; k++) begin
        w_acc = w_acc + ACC_W'($signed({1'b0, w_win_nxt[c][k]})) * ACC_W'(r_shadow[k]);
      end
      w_shf = w_acc >>> SHIFT;
      if (w_shf[ACC_W-1])       w_result[c*DATA_W +: DATA_W] = '0;
      else if (w_shf > SAT_MAX) w_result[c*DATA_W +: DATA_W] = '1;
      else                      w_result[c*DATA_W +: DATA_W] = w_shf[DATA_W-1:0];
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_col       <= '0;
      r_flush_cnt <= '0;
      r_sof       <= 1'b1;
      r_mode      <= 1'b0;
      r_eof_pend  <= 1'b0;
      r_vld       <= 1'b0;
      r_eor       <= 1'b0;
      r_eof       <= 1'b0;
      r_data      <= '0;
      // NOTE: the window is a small register array, not a RAM, so clearing it
      // on reset is cheap and keeps the first outputs of a frame deterministic.
      for (int c = 0; c < CH; c++)
        for (int k = 0; k < KERNEL_W; k++) r_win[c][k] <= '0;
      for (int k = 0; k < KERNEL_W; k++) begin
        if (k == R) begin
          r_coef[k]   <= COEF_W'(1 << SHIFT);
          r_shadow[k] <= COEF_W'(1 << SHIFT);
        end else begin
          r_coef[k]   <= '0;
          r_shadow[k] <= '0;
        end
      end
    end else begin
      // Out-of-range tap indices simply match no register.
      for (int k = 0; k < KERNEL_W; k++) begin
        if (i_cfg_we && i_cfg_addr == 4'(k)) r_coef[k] <= i_cfg_wdata;
      end

      r_win <= w_win_nxt;

      if (w_accept) begin
        if (r_sof) begin
          r_shadow <= r_coef;
          r_mode   <= i_mode;
        end
        r_sof <= i_eof;
        if (w_row_end) begin
          r_col       <= '0;
          r_flush_cnt <= '0;
          r_eof_pend  <= i_eof;
        end else begin
          r_col <= r_col + COL_W'(1);
        end
      end

      if (w_step) r_flush_cnt <= r_flush_cnt + 4'd1;

      if (w_emit) begin
        r_vld  <= 1'b1;
        r_eor  <= w_tag_eor;
        r_eof  <= w_tag_eof;
        r_data <= w_result;
      end else if (i_rdy) begin
        r_vld <= 1'b0;
      end
    end
  end

  assign o_vld  = r_vld;
  assign o_eor  = r_eor;
  assign o_eof  = r_eof;
  assign o_data = r_data;

endmodule
